load_track_unit: RTL and testbench

LOAD_TRACK_UNIT -- requirements
Module: load_track_unit

---
 rtl/load_track_unit.sv | 153 +++++++++++++++
 tb/tb_load_track_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_track_unit.sv
// load_track_unit: tracks in-flight loads between issue and write-back.
// Pending loads are queued in order as {rd, func3}. Each accepted load is
// forwarded to the MMU one cycle later. In-order MMU responses pop the head
// entry and produce a sign- or zero-extended write-back one cycle later.
// A combinational scoreboard query reports which registers still have a
// pending load.
//
// Ports:
//   cpu_clk_aon, i_rst            clock; asynchronous active-high reset
//   iss_valid/iss_ready           load issue handshake
//   iss_rd, iss_func3, iss_addr   load destination, type and byte address
//   mmu_rd_req, mmu_rd_addr       registered one-cycle MMU request
//   mmu_rd_valid, mmu_rd_data     in-order MMU response
//   q_rs1/q_rs2 -> q_busy1/2      combinational pending-load hazard query
//   wb_valid, wb_rd, wb_data      registered write-back
//   err_unexp                     sticky flag: response arrived with nothing pending
//   occupancy                     number of pending loads
module load_track_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned NREG  = 32
) (
    input  logic                      cpu_clk_aon,
    input  logic                      i_rst,
    input  logic                      iss_valid,
    output logic                      iss_ready,
    input  logic [$clog2(NREG)-1:0]   iss_rd,
    input  logic [2:0]                iss_func3,
    input  logic [XLEN-1:0]           iss_addr,
    output logic                      mmu_rd_req,
    output logic [XLEN-1:0]           mmu_rd_addr,
    input  logic                      mmu_rd_valid,
    input  logic [XLEN-1:0]           mmu_rd_data,
    input  logic [$clog2(NREG)-1:0]   q_rs1,
    input  logic [$clog2(NREG)-1:0]   q_rs2,
    output logic                      q_busy1,
    output logic                      q_busy2,
    output logic                      wb_valid,
    output logic [$clog2(NREG)-1:0]   wb_rd,
    output logic [XLEN-1:0]           wb_data,
    output logic                      err_unexp,
    output logic [$clog2(DEPTH):0]    occupancy
);

    localparam int unsigned RW = $clog2(NREG);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [RW-1:0] rd;
        logic [2:0]    func3;
    } entry_t;

    entry_t        fifo_q [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic   full;
    logic   func3_ok;
    logic   push;
    logic   pop;
    logic   unexp;
    entry_t head;

    // Load result extension selected by the head entry's load type
    function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        case (f3)
            F3_LB:   r = {{(XLEN-8){d[7]}}, d[7:0]};
            F3_LH:   r = {{(XLEN-16){d[15]}}, d[15:0]};
            F3_LBU:  r = {{(XLEN-8){1'b0}}, d[7:0]};
            F3_LHU:  r = {{(XLEN-16){1'b0}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Handshake and push/pop decode
    always_comb begin
        full      = (count == CW'(DEPTH));
        func3_ok  = (iss_func3 == F3_LB) || (iss_func3 == F3_LH) || (iss_func3 == F3_LW) ||
                    (iss_func3 == F3_LBU) || (iss_func3 == F3_LHU);
        // When full, a response this cycle necessarily pops and frees a slot
        iss_ready = !i_rst && (!full || mmu_rd_valid);
        pop       = mmu_rd_valid && (count != '0);
        unexp     = mmu_rd_valid && (count == '0);
        // Unsupported load types complete the handshake but are discarded
        push      = iss_valid && iss_ready && func3_ok;
        head      = fifo_q[rd_ptr];
    end

    // Scoreboard query over the valid window [rd_ptr, rd_ptr + count)
    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        q_busy1 = 1'b0;
        q_busy2 = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                if (fifo_q[idx].rd == q_rs1) q_busy1 = 1'b1;
                if (fifo_q[idx].rd == q_rs2) q_busy2 = 1'b1;
            end
        end
        if (q_rs1 == '0) q_busy1 = 1'b0;
        if (q_rs2 == '0) q_busy2 = 1'b0;
    end

    // Queue state, MMU request and write-back registers
    always_ff @(posedge cpu_clk_aon or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            mmu_rd_req  <= 1'b0;
            mmu_rd_addr <= '0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            err_unexp   <= 1'b0;
        end else begin
            mmu_rd_req <= push;
            wb_valid   <= pop;
            if (push) begin
                fifo_q[wr_ptr] <= '{rd: iss_rd, func3: iss_func3};
                wr_ptr         <= wr_ptr + PW'(1);
                mmu_rd_addr    <= iss_addr;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PW'(1);
                wb_rd   <= head.rd;
                wb_data <= extend(head.func3, mmu_rd_data);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (unexp) err_unexp <= 1'b1;
        end
    end

    assign occupancy = count;

endmodule

// File: tb/tb_load_track_unit.sv
// Bench for load_track_unit: directed vector table plus randomized traffic,
// all compared against a queue-based reference model of pending loads.
module tb_load_track_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NREG  = 32;

    logic        clk;
    logic        rst;
    logic        iss_valid;
    logic        iss_ready;
    logic [4:0]  iss_rd;
    logic [2:0]  iss_func3;
    logic [31:0] iss_addr;
    logic        mmu_rd_req;
    logic [31:0] mmu_rd_addr;
    logic        mmu_rd_valid;
    logic [31:0] mmu_rd_data;
    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic        q_busy1;
    logic        q_busy2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err_unexp;
    logic [2:0]  occupancy;

    load_track_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .NREG(NREG)) dut (
        .cpu_clk_aon (clk),
        .i_rst       (rst),
        .iss_valid   (iss_valid),
        .iss_ready   (iss_ready),
        .iss_rd      (iss_rd),
        .iss_func3   (iss_func3),
        .iss_addr    (iss_addr),
        .mmu_rd_req  (mmu_rd_req),
        .mmu_rd_addr (mmu_rd_addr),
        .mmu_rd_valid(mmu_rd_valid),
        .mmu_rd_data (mmu_rd_data),
        .q_rs1       (q_rs1),
        .q_rs2       (q_rs2),
        .q_busy1     (q_busy1),
        .q_busy2     (q_busy2),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .err_unexp   (err_unexp),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    typedef struct {
        logic [4:0] rd;
        logic [2:0] f3;
    } ent_t;
    ent_t        mq[$];
    logic        m_err;
    logic [31:0] m_addr;
    logic [4:0]  m_wbrd;
    logic [31:0] m_wbd;

    // Snapshots of DUT outputs for the directed table
    logic        c_rdy, c_b1, r_req, r_wbv, r_err;
    logic [2:0]  r_occ;
    logic [31:0] r_wbd;

    typedef struct {
        logic        rst, iv, mv;
        logic [4:0]  rd, rs1;
        logic [2:0]  f3;
        logic [31:0] addr, data;
        logic        e_rdy, e_b1, e_req, e_wbv, e_err;
        logic [2:0]  e_occ;
        logic [31:0] e_wbd;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t row(input logic r, input logic iv, input logic [4:0] rd,
                                 input logic [2:0] f3, input logic [31:0] addr, input logic mv,
                                 input logic [31:0] data, input logic [4:0] rs1,
                                 input logic e_rdy, input logic e_b1, input logic [2:0] e_occ,
                                 input logic e_req, input logic e_wbv, input logic [31:0] e_wbd,
                                 input logic e_err);
        vec_t v;
        v.rst = r; v.iv = iv; v.rd = rd; v.f3 = f3; v.addr = addr; v.mv = mv;
        v.data = data; v.rs1 = rs1; v.e_rdy = e_rdy; v.e_b1 = e_b1; v.e_occ = e_occ;
        v.e_req = e_req; v.e_wbv = e_wbv; v.e_wbd = e_wbd; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit f3_ok(input logic [2:0] f3);
        return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

    // Expected load result from the raw data using plain arithmetic
    function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [31:0] d);
        longint v;
        case (f3)
            3'd0: begin v = longint'(d) % 256;   if (v >= 128)   v -= 256;   end
            3'd1: begin v = longint'(d) % 65536; if (v >= 32768) v -= 65536; end
            3'd4: v = longint'(d) % 256;
            3'd5: v = longint'(d) % 65536;
            default: v = longint'(d);
        endcase
        return 32'(v);
    endfunction

    // One clock cycle with inputs already driven: check combinational outputs,
    // advance the model, then check registered outputs after the edge.
    task automatic run_cycle(input string tag);
        bit e_rdy, e_b1, e_b2, push, pop, wb_chk, m_req, m_wbv;
        int n;
        #1;
        if (rst) begin
            mq.delete();
            m_err = 1'b0; m_addr = '0; m_wbrd = '0; m_wbd = '0;
        end
        n = mq.size();
        e_rdy = !rst && ((n < int'(DEPTH)) || mmu_rd_valid);
        e_b1 = 1'b0;
        e_b2 = 1'b0;
        foreach (mq[k]) begin
            if (q_rs1 != 0 && mq[k].rd == q_rs1) e_b1 = 1'b1;
            if (q_rs2 != 0 && mq[k].rd == q_rs2) e_b2 = 1'b1;
        end
        c_rdy = iss_ready;
        c_b1  = q_busy1;
        chk({tag, " iss_ready"}, 32'(iss_ready), 32'(e_rdy));
        chk({tag, " q_busy1"},   32'(q_busy1),   32'(e_b1));
        chk({tag, " q_busy2"},   32'(q_busy2),   32'(e_b2));
        chk({tag, " occ_pre"},   32'(occupancy), 32'(n));

        push   = iss_valid && e_rdy && f3_ok(iss_func3);
        pop    = !rst && mmu_rd_valid && n > 0;
        m_req  = push;
        m_wbv  = pop;
        wb_chk = pop || rst;
        if (push) m_addr = iss_addr;
        if (pop) begin
            m_wbrd = mq[0].rd;
            m_wbd  = ref_ext(mq[0].f3, mmu_rd_data);
            void'(mq.pop_front());
        end
        if (!rst && mmu_rd_valid && n == 0) m_err = 1'b1;
        if (push) mq.push_back('{rd: iss_rd, f3: iss_func3});

        @(posedge clk);
        #1;
        r_req = mmu_rd_req; r_wbv = wb_valid; r_err = err_unexp;
        r_occ = occupancy;  r_wbd = wb_data;
        chk({tag, " mmu_rd_req"},  32'(mmu_rd_req), 32'(m_req));
        chk({tag, " mmu_rd_addr"}, mmu_rd_addr,     m_addr);
        chk({tag, " wb_valid"},    32'(wb_valid),   32'(m_wbv));
        chk({tag, " err_unexp"},   32'(err_unexp),  32'(m_err));
        chk({tag, " occupancy"},   32'(occupancy),  32'(mq.size()));
        if (wb_chk) begin
            chk({tag, " wb_rd"},   32'(wb_rd), 32'(m_wbrd));
            chk({tag, " wb_data"}, wb_data,    m_wbd);
        end
    endtask

    task automatic apply(input vec_t v);
        rst = v.rst; iss_valid = v.iv; iss_rd = v.rd; iss_func3 = v.f3; iss_addr = v.addr;
        mmu_rd_valid = v.mv; mmu_rd_data = v.data; q_rs1 = v.rs1; q_rs2 = 5'd0;
    endtask

    initial begin
        rst = 1'b1; iss_valid = 0; iss_rd = 0; iss_func3 = 0; iss_addr = 0;
        mmu_rd_valid = 0; mmu_rd_data = 0; q_rs1 = 0; q_rs2 = 0;

        //            rst iv rd  f3    addr          mv data           rs1 rdy b1 occ req wbv wbd            err
        tbl.push_back(row(1, 0, 0, 3'd0, 32'h0,     0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0,        0));
        // lb to rd5, busy tracking, sign-extended write-back
        tbl.push_back(row(0, 1, 5, 3'd0, 32'h100,   0, 32'h0,        5, 1, 0, 1, 1, 0, 32'h0,        0));
        tbl.push_back(row(0, 0, 0, 3'd0, 32'h0,     0, 32'h0,        5, 1, 1, 1, 0, 0, 32'h0,        0));
        tbl.push_back(row(0, 0, 0, 3'd0, 32'h0,     1, 32'h80,       5, 1, 1, 0, 0, 1, 32'hFFFFFF80, 0));
        tbl.push_back(row(0, 0, 0, 3'd0, 32'h0,     0, 32'h0,        5, 1, 0, 0, 0, 0, 32'h0,        0));
        // fill to DEPTH, then issue and respond in the same cycle while full
        tbl.push_back(row(0, 1, 1, 3'd2, 32'h200,   0, 32'h0,        0, 1, 0, 1, 1, 0, 32'h0,        0));
        tbl.push_back(row(0, 1, 2, 3'd2, 32'h204,   0, 32'h0,        0, 1, 0, 2, 1, 0, 32'h0,        0));
        tbl.push_back(row(0, 1, 3, 3'd2, 32'h208,   0, 32'h0,        0, 1, 0, 3, 1, 0, 32'h0,        0));
        tbl.push_back(row(0, 1, 4, 3'd2, 32'h20C,   0, 32'h0,        0, 1, 0, 4, 1, 0, 32'h0,        0));
        tbl.push_back(row(0, 0, 0, 3'd0, 32'h0,     0, 32'h0,        4, 0, 1, 4, 0, 0, 32'h0,        0));
        tbl.push_back(row(0, 1, 6, 3'd2, 32'h300,   1, 32'h11111111, 6, 1, 0, 4, 1, 1, 32'h11111111, 0));
        tbl.push_back(row(0, 0, 0, 3'd0, 32'h0,     1, 32'h22222222, 0, 1, 0, 3, 0, 1, 32'h22222222, 0));
        tbl.push_back(row(0, 0, 0, 3'd0, 32'h0,     1, 32'h33333333, 0, 1, 0, 2, 0, 1, 32'h33333333, 0));
        tbl.push_back(row(0, 0, 0, 3'd0, 32'h0,     1, 32'h44444444, 0, 1, 0, 1, 0, 1, 32'h44444444, 0));
        tbl.push_back(row(0, 0, 0, 3'd0, 32'h0,     1, 32'h55555555, 6, 1, 1, 0, 0, 1, 32'h55555555, 0));
        // lhu then lw to rd3: stays busy until the second write-back
        tbl.push_back(row(0, 1, 3, 3'd5, 32'h400,   0, 32'h0,        3, 1, 0, 1, 1, 0, 32'h0,        0));
        tbl.push_back(row(0, 1, 3, 3'd2, 32'h404,   0, 32'h0,        3, 1, 1, 2, 1, 0, 32'h0,        0));
        tbl.push_back(row(0, 0, 0, 3'd0, 32'h0,     1, 32'h12348765, 3, 1, 1, 1, 0, 1, 32'h00008765, 0));
        tbl.push_back(row(0, 0, 0, 3'd0, 32'h0,     1, 32'hDEADBEEF, 3, 1, 1, 0, 0, 1, 32'hDEADBEEF, 0));
        tbl.push_back(row(0, 0, 0, 3'd0, 32'h0,     0, 32'h0,        3, 1, 0, 0, 0, 0, 32'h0,        0));
        // response with nothing pending: sticky error, no write-back
        tbl.push_back(row(0, 0, 0, 3'd0, 32'h0,     1, 32'hAAAA,     0, 1, 0, 0, 0, 0, 32'h0,        1));
        tbl.push_back(row(0, 0, 0, 3'd0, 32'h0,     0, 32'h0,        0, 1, 0, 0, 0, 0, 32'h0,        1));
        tbl.push_back(row(1, 0, 0, 3'd0, 32'h0,     0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0,        0));
        // reset with loads pending discards them
        tbl.push_back(row(0, 1, 7, 3'd1, 32'h500,   0, 32'h0,        0, 1, 0, 1, 1, 0, 32'h0,        0));
        tbl.push_back(row(0, 1, 8, 3'd4, 32'h504,   0, 32'h0,        0, 1, 0, 2, 1, 0, 32'h0,        0));
        tbl.push_back(row(0, 1, 9, 3'd1, 32'h508,   0, 32'h0,        7, 1, 1, 3, 1, 0, 32'h0,        0));
        tbl.push_back(row(1, 0, 0, 3'd0, 32'h0,     0, 32'h0,        7, 0, 0, 0, 0, 0, 32'h0,        0));
        tbl.push_back(row(0, 0, 0, 3'd0, 32'h0,     1, 32'h1234,     7, 1, 0, 0, 0, 0, 32'h0,        1));
        tbl.push_back(row(1, 0, 0, 3'd0, 32'h0,     0, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0,        0));
        // unsupported func3 dropped; rd0 occupies a slot but is never busy
        tbl.push_back(row(0, 1, 10, 3'd3, 32'h600,  0, 32'h0,        0, 1, 0, 0, 0, 0, 32'h0,        0));
        tbl.push_back(row(0, 1, 0, 3'd2, 32'h700,   0, 32'h0,        0, 1, 0, 1, 1, 0, 32'h0,        0));
        tbl.push_back(row(0, 0, 0, 3'd0, 32'h0,     0, 32'h0,        0, 1, 0, 1, 0, 0, 32'h0,        0));
        tbl.push_back(row(0, 0, 0, 3'd0, 32'h0,     1, 32'h000000FF, 0, 1, 0, 0, 0, 1, 32'h000000FF, 0));
        // remaining extensions: lbu and lh with sign bit set
        tbl.push_back(row(0, 1, 1, 3'd4, 32'h800,   0, 32'h0,        0, 1, 0, 1, 1, 0, 32'h0,        0));
        tbl.push_back(row(0, 0, 0, 3'd0, 32'h0,     1, 32'h123456F0, 0, 1, 0, 0, 0, 1, 32'h000000F0, 0));
        tbl.push_back(row(0, 1, 2, 3'd1, 32'h804,   0, 32'h0,        0, 1, 0, 1, 1, 0, 32'h0,        0));
        tbl.push_back(row(0, 0, 0, 3'd0, 32'h0,     1, 32'h00008001, 0, 1, 0, 0, 0, 1, 32'hFFFF8001, 0));

        foreach (tbl[i]) begin
            string t;
            t = $sformatf("row%0d", i);
            apply(tbl[i]);
            run_cycle(t);
            chk({t, " tbl_ready"}, 32'(c_rdy), 32'(tbl[i].e_rdy));
            chk({t, " tbl_busy1"}, 32'(c_b1),  32'(tbl[i].e_b1));
            chk({t, " tbl_occ"},   32'(r_occ), 32'(tbl[i].e_occ));
            chk({t, " tbl_req"},   32'(r_req), 32'(tbl[i].e_req));
            chk({t, " tbl_wbv"},   32'(r_wbv), 32'(tbl[i].e_wbv));
            chk({t, " tbl_err"},   32'(r_err), 32'(tbl[i].e_err));
            if (tbl[i].e_wbv) chk({t, " tbl_wbd"}, r_wbd, tbl[i].e_wbd);
        end

        // Randomized traffic against the reference model
        for (int c = 0; c < 2000; c++) begin
            rst          = ($urandom_range(0, 99) == 0);
            iss_valid    = ($urandom_range(0, 9) < 7);
            iss_rd       = 5'($urandom_range(0, 7));
            iss_func3    = 3'($urandom_range(0, 7));
            iss_addr     = $urandom;
            mmu_rd_valid = ($urandom_range(0, 9) < 4);
            mmu_rd_data  = $urandom;
            q_rs1        = 5'($urandom_range(0, 7));
            q_rs2        = 5'($urandom_range(0, 7));
            run_cycle($sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
